// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester handshakes and shared-bus signals for bus_arbiter
interface bus_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              owner;
    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, bus_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata, bus_addr, bus_we, bus_wdata, owner
    );
    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, bus_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata, bus_addr, bus_we, bus_wdata, owner
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter, one 3-cycle transaction at a time
module bus_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic rst,
    bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;
    logic last;
    logic win;
    logic win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    assign bus.m0_rdata = bus.m0_ack ? bus.bus_rdata : '0;
    assign bus.m1_rdata = bus.m1_ack ? bus.bus_rdata : '0;
    // pick master 1 when it is the sole requester or when it was not served last
    always_comb begin
        win = bus.m1_req & (~bus.m0_req | ~last);
        win_we = win ? bus.m1_we : bus.m0_we;
        win_addr = win ? bus.m1_addr : bus.m0_addr;
        win_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    end
    // IDLE latches the winner onto the bus, ACCESS drives it, RESP acks and clears
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last <= 1'b0;
            bus.owner <= 1'b0;
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;
            bus.bus_we <= 1'b0;
            bus.bus_addr <= '0;
            bus.bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (bus.m0_req | bus.m1_req) begin
                    bus.owner <= win;
                    bus.bus_we <= win_we;
                    bus.bus_addr <= win_addr;
                    bus.bus_wdata <= win_wdata;
                    state <= ACCESS;
                end
                ACCESS: begin
                    bus.bus_we <= 1'b0;
                    bus.m0_ack <= ~bus.owner;
                    bus.m1_ack <= bus.owner;
                    state <= RESP;
                end
                RESP: begin
                    bus.m0_ack <= 1'b0;
                    bus.m1_ack <= 1'b0;
                    bus.bus_addr <= '0;
                    bus.bus_wdata <= '0;
                    last <= bus.owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
